// File: rtl/memshare_wbaddr_ctrl_pkg.sv
// Shared configuration for the memShare write-back address controller:
// buffer/DRC geometry constants and the controller FSM state type.
package memshare_wbaddr_ctrl_pkg;

  localparam int MSGPASS_BUFF_ADDR_WIDTH = 8;
  localparam int MEMSHARE_DRC_NUM        = 2;
  localparam int MEMSHARE_DRC0           = 0;
  localparam int MEMSHARE_DRC1           = 1;
  localparam int MEMSHARE_WB_TRACK_DEPTH = 8;

  typedef enum logic [1:0] {
    WB_IDLE   = 2'd0,
    WB_ACTIVE = 2'd1,
    WB_DRAIN  = 2'd2
  } memshare_wb_state_e;

endpackage

// File: rtl/memshare_wbaddr_ctrl_addr_fifo.sv
// Address-tracking FIFO: synchronous, async active-low reset, registered read
// data that holds its value between pops, and synchronous clear.
module memshare_wbaddr_ctrl_addr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // The caller never pushes into a full FIFO unless it pops in the same cycle.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + PW'(1);
      end
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/memshare_wbaddr_ctrl.sv
// Write-back address controller: records (optionally rebased) read addresses
// during a memShare period and replays them in order as buffer write addresses.
module memshare_wbaddr_ctrl
  import memshare_wbaddr_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = MSGPASS_BUFF_ADDR_WIDTH,
  parameter int DRC_NUM     = MEMSHARE_DRC_NUM,
  parameter int TRACK_DEPTH = MEMSHARE_WB_TRACK_DEPTH,
  parameter int ROW_NUM     = 32
) (
  input  logic                  sys_clk,
  input  logic                  rstn,
  input  logic                  scu_begin_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                  rd_vld_i,
  input  logic [DRC_NUM-1:0]    is_drc_i,
  input  logic [ADDR_WIDTH-1:0] drc_base_addr_i,
  input  logic                  wb_vld_i,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic                  wr_en_o,
  output logic                  track_full_o,
  output logic                  track_empty_o,
  output logic                  ovf_err_o,
  output logic                  unf_err_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            dbg_state
);

  localparam int CW = $clog2(ROW_NUM + 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(ROW_NUM);

  memshare_wb_state_e    state;
  logic [CW-1:0]         push_cnt;
  logic [CW-1:0]         wr_cnt;
  logic                  begin_ok;
  logic                  push_req;
  logic                  pop_req;
  logic                  push_ok;
  logic                  pop_ok;
  logic [ADDR_WIDTH-1:0] store_addr;
  logic                  drc_unused;

  // A full FIFO still accepts a push when a pop frees the head slot this cycle;
  // an empty FIFO never forwards a same-cycle push to the write port.
  always_comb begin
    begin_ok   = (state == WB_IDLE) && scu_begin_i;
    push_req   = (state == WB_ACTIVE) && rd_vld_i;
    pop_req    = (state != WB_IDLE) && wb_vld_i;
    pop_ok     = pop_req && !track_empty_o;
    push_ok    = push_req && (!track_full_o || pop_ok);
    store_addr = is_drc_i[MEMSHARE_DRC1] ? ADDR_WIDTH'(rd_addr_i + drc_base_addr_i) : rd_addr_i;
  end

  assign drc_unused = ^is_drc_i;

  memshare_wbaddr_ctrl_addr_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (TRACK_DEPTH)
  ) u_fifo (
    .clk       (sys_clk),
    .rst_n     (rstn),
    .clr       (begin_ok),
    .push      (push_ok),
    .push_data (store_addr),
    .pop       (pop_ok),
    .rd_data   (wr_addr_o),
    .full      (track_full_o),
    .empty     (track_empty_o)
  );

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state     <= WB_IDLE;
      push_cnt  <= '0;
      wr_cnt    <= '0;
      ovf_err_o <= 1'b0;
      unf_err_o <= 1'b0;
      wr_en_o   <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      wr_en_o <= pop_ok;
      done_o  <= 1'b0;
      if (push_ok) push_cnt <= push_cnt + CW'(1);
      if (pop_ok)  wr_cnt   <= wr_cnt + CW'(1);
      if (push_req && track_full_o && !pop_ok) ovf_err_o <= 1'b1;
      if (pop_req && track_empty_o)            unf_err_o <= 1'b1;
      case (state)
        WB_IDLE: begin
          if (scu_begin_i) begin
            state     <= WB_ACTIVE;
            push_cnt  <= '0;
            wr_cnt    <= '0;
            ovf_err_o <= 1'b0;
            unf_err_o <= 1'b0;
          end
        end
        WB_ACTIVE: begin
          if (push_ok && (push_cnt + CW'(1) == ROW_LAST)) state <= WB_DRAIN;
        end
        WB_DRAIN: begin
          if (pop_ok && (wr_cnt + CW'(1) == ROW_LAST)) begin
            state  <= WB_IDLE;
            done_o <= 1'b1;
          end
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

  assign busy_o    = (state != WB_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_memshare_wbaddr_ctrl.sv
// Bench for memshare_wbaddr_ctrl: directed memShare periods plus random traffic,
// checked every cycle against a queue-based model of the period rules.
module tb_memshare_wbaddr_ctrl;
  import memshare_wbaddr_ctrl_pkg::*;

  localparam int AW    = 8;
  localparam int DEPTH = 8;
  localparam int ROWS  = 12;
  localparam int EW    = AW + 7;

  logic          sys_clk = 1'b0;
  logic          rstn = 1'b0;
  logic          scu_begin = 1'b0;
  logic          rd_vld = 1'b0;
  logic          wb_vld = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [AW-1:0] drc_base = '0;
  logic [1:0]    is_drc = '0;
  logic [AW-1:0] wr_addr;
  logic          wr_en, full, empty, ovf, unf, busy, done;
  logic [1:0]    dbg_state;

  memshare_wbaddr_ctrl #(
    .ADDR_WIDTH  (AW),
    .DRC_NUM     (2),
    .TRACK_DEPTH (DEPTH),
    .ROW_NUM     (ROWS)
  ) dut (
    .sys_clk         (sys_clk),
    .rstn            (rstn),
    .scu_begin_i     (scu_begin),
    .rd_addr_i       (rd_addr),
    .rd_vld_i        (rd_vld),
    .is_drc_i        (is_drc),
    .drc_base_addr_i (drc_base),
    .wb_vld_i        (wb_vld),
    .wr_addr_o       (wr_addr),
    .wr_en_o         (wr_en),
    .track_full_o    (full),
    .track_empty_o   (empty),
    .ovf_err_o       (ovf),
    .unf_err_o       (unf),
    .busy_o          (busy),
    .done_o          (done),
    .dbg_state       (dbg_state)
  );

  // clock / counters
  always #5 sys_clk = ~sys_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // expected per-cycle record: {wr_en, done, full, empty, busy, ovf, unf, wr_addr}
  logic [EW-1:0] exp_q[$];

  // reference model state
  int            m_mode = 0;   // 0 idle, 1 collecting, 2 draining
  logic [AW-1:0] m_q[$];
  int            m_pushes = 0;
  int            m_writes = 0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  logic [AW-1:0] m_last = '0;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic en, dn, pop_ok, push;
    logic [AW-1:0] a;
    en = 1'b0;
    dn = 1'b0;
    if (!rstn) begin
      m_mode = 0; m_q.delete(); m_pushes = 0; m_writes = 0;
      m_ovf = 1'b0; m_unf = 1'b0; m_last = '0;
    end else if (m_mode == 0) begin
      if (scu_begin) begin
        m_mode = 1; m_q.delete(); m_pushes = 0; m_writes = 0;
        m_ovf = 1'b0; m_unf = 1'b0;
      end
    end else begin
      pop_ok = wb_vld && (m_q.size() > 0);
      if (wb_vld && m_q.size() == 0) m_unf = 1'b1;
      push = (m_mode == 1) && rd_vld;
      a = is_drc[1] ? AW'(rd_addr + drc_base) : rd_addr;
      if (pop_ok) begin
        m_last = m_q.pop_front();
        en = 1'b1;
        m_writes++;
      end
      if (push) begin
        if (m_q.size() == DEPTH) m_ovf = 1'b1;
        else begin
          m_q.push_back(a);
          m_pushes++;
        end
      end
      if (m_mode == 2 && m_writes == ROWS) begin
        m_mode = 0;
        dn = 1'b1;
      end else if (m_mode == 1 && m_pushes == ROWS) begin
        m_mode = 2;
      end
    end
    exp_q.push_back({en, dn, m_q.size() == DEPTH, m_q.size() == 0, m_mode != 0, m_ovf, m_unf, m_last});
  endtask

  // monitor / scoreboard
  always @(negedge sys_clk) begin : mon
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wr_en",   AW'(wr_en), AW'(e[14]));
      chk("done",    AW'(done),  AW'(e[13]));
      chk("full",    AW'(full),  AW'(e[12]));
      chk("empty",   AW'(empty), AW'(e[11]));
      chk("busy",    AW'(busy),  AW'(e[10]));
      chk("ovf_err", AW'(ovf),   AW'(e[9]));
      chk("unf_err", AW'(unf),   AW'(e[8]));
      chk("wr_addr", wr_addr,    e[AW-1:0]);
    end
  end

  // driver tasks
  task automatic step(input logic b, input logic rv, input logic [AW-1:0] ra,
                      input logic [1:0] drc, input logic wv);
    scu_begin = b;
    rd_vld    = rv;
    rd_addr   = ra;
    is_drc    = drc;
    wb_vld    = wv;
    @(posedge sys_clk);
    #1;
    model_step();
  endtask

  task automatic do_async_reset();
    @(negedge sys_clk);
    #1 rstn = 1'b0;
    #1;
    chk("arst_wr_en",  AW'(wr_en), '0);
    chk("arst_wr_addr", wr_addr,   '0);
    chk("arst_full",   AW'(full),  '0);
    chk("arst_empty",  AW'(empty), AW'(1));
    chk("arst_ovf",    AW'(ovf),   '0);
    chk("arst_unf",    AW'(unf),   '0);
    chk("arst_busy",   AW'(busy),  '0);
    chk("arst_done",   AW'(done),  '0);
    chk("arst_state",  AW'(dbg_state), AW'(WB_IDLE));
    step(1'b0, 1'b0, '0, 2'b00, 1'b0);
    step(1'b1, 1'b1, '0, 2'b00, 1'b1);
    rstn = 1'b1;
  endtask

  initial begin
    // reset, then inputs that must be ignored while idle
    step(1'b0, 1'b0, '0, 2'b00, 1'b0);
    step(1'b0, 1'b0, '0, 2'b00, 1'b0);
    rstn = 1'b1;
    step(1'b0, 1'b1, 8'h33, 2'b10, 1'b0);
    step(1'b0, 1'b0, '0, 2'b00, 1'b1);

    // plain period; scu_begin while collecting must not restart it
    step(1'b1, 1'b0, '0, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, AW'(8'h10 + i), 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 2'b00, 1'b1);
    for (int i = 4; i < ROWS; i++) step(1'b1, 1'b1, AW'(8'h10 + i), 2'b01, 1'(i % 2));
    for (int i = 0; i < ROWS; i++) step(1'b0, 1'b0, '0, 2'b00, 1'b1);

    // rebasing with wraparound
    drc_base = 8'hF0;
    step(1'b1, 1'b0, '0, 2'b00, 1'b0);
    step(1'b0, 1'b1, 8'h20, 2'b10, 1'b0);
    step(1'b0, 1'b1, 8'h21, 2'b01, 1'b0);
    for (int i = 2; i < ROWS; i++)
      step(1'b0, 1'b1, AW'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < ROWS + 2; i++) step(1'b0, 1'b0, '0, 2'b00, 1'b1);

    // overflow, then push+pop while full, then drain
    step(1'b1, 1'b0, '0, 2'b00, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, AW'(8'h40 + i), 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, AW'(8'h50 + i), 2'b00, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b1, 8'h77, 2'b00, 1'b1);

    // underflow, then reset with entries queued
    step(1'b1, 1'b0, '0, 2'b00, 1'b0);
    step(1'b0, 1'b1, 8'h60, 2'b00, 1'b1);
    for (int i = 1; i < 4; i++) step(1'b0, 1'b1, AW'(8'h60 + i), 2'b00, 1'b0);
    do_async_reset();

    // clean period after reset
    step(1'b1, 1'b0, '0, 2'b00, 1'b0);
    for (int i = 0; i < ROWS; i++) step(1'b0, 1'b1, AW'(8'h80 + i), 2'b00, 1'(i > 2));
    for (int i = 0; i < ROWS; i++) step(1'b0, 1'b0, '0, 2'b00, 1'b1);

    // random traffic with one mid-stream reset
    for (int i = 0; i < 900; i++) begin
      if (i % 50 == 0) drc_base = AW'($urandom_range(0, 255));
      if (i == 450) do_async_reset();
      step(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) != 0),
           AW'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 2'b00, 1'b0);
    @(negedge sys_clk);
    #1;
    chk("scoreboard_drained", AW'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/memshare_wbaddr_ctrl.md
# memShare_wbAddr_ctrl

Write-back address controller for the message-passing buffer during the SCU.memShare() period. It records every read address issued to the buffer, rebasing DRC1-flagged requests onto the DRC base address. It then replays the recorded addresses, in order, as write addresses when the updated messages return from the decoding pipeline. It sits on the write port of the message-passing buffer, mirroring the read-side request-address generator.

## Interface
Parameters:
- ADDR_WIDTH, default msgPass_config_pkg::MSGPASS_BUFF_ADDR_WIDTH (8): buffer address width.
- DRC_NUM, default memShare_config_pkg::MEMSHARE_DRC_NUM (2): width of the DRC flag vector.
- TRACK_DEPTH, default 8: depth of the address-tracking FIFO; must be a power of two, at least 2.
- ROW_NUM, default 32: number of writes per memShare period; must be at least 1.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- scu_begin_i  in  1  single-cycle pulse marking the start of SCU.memShare().
- rd_addr_i  in  ADDR_WIDTH  read address just issued to the buffer.
- rd_vld_i  in  1  rd_addr_i is valid this cycle (push).
- is_drc_i  in  DRC_NUM  DRC result for the current read; bit MEMSHARE_DRC1 selects rebasing.
- drc_base_addr_i  in  ADDR_WIDTH  rebasing base address.
- wb_vld_i  in  1  updated message arriving for write-back (pop).
- wr_addr_o  out  ADDR_WIDTH  buffer write address; reset 0.
- wr_en_o  out  1  buffer write enable; reset 0.
- track_full_o / track_empty_o  out  1  FIFO status; reset 0 / 1.
- ovf_err_o / unf_err_o  out  1  sticky overflow / underflow flags; reset 0.
- busy_o  out  1  state is not IDLE; reset 0.
- done_o  out  1  single-cycle pulse when a period completes; reset 0.

## Operation
- FSM with three states: IDLE, ACTIVE, DRAIN. Reset state is IDLE.
  - IDLE → ACTIVE on scu_begin_i. This also clears the push and write counters, the FIFO pointers and both error flags.
  - ACTIVE → DRAIN when the accepted-push count reaches ROW_NUM.
  - DRAIN → IDLE when the write count reaches ROW_NUM. done_o pulses in the same cycle as the transition.
  - scu_begin_i outside IDLE is ignored.
- Push is accepted only in ACTIVE with rd_vld_i = 1.
  - Stored address = rd_addr_i + drc_base_addr_i (mod 2^ADDR_WIDTH) if is_drc_i[MEMSHARE_DRC1] = 1.
  - Otherwise the stored address is rd_addr_i.
- rd_vld_i in IDLE or DRAIN is ignored, with no error raised.
- Pop happens in ACTIVE or DRAIN when wb_vld_i = 1 and the FIFO is not empty. It drives wr_en_o = 1 and wr_addr_o = the head entry.
- FIFO boundary rules:
  - Push when full with no simultaneous pop: the entry is dropped and ovf_err_o is set.
  - Push when full with a simultaneous pop: both are performed and the count is unchanged.
  - Pop when empty: wr_en_o stays 0 and unf_err_o is set. A simultaneous push is not bypassed to the output.
  - wb_vld_i in IDLE: ignored.
- Error flags stay set until the next accepted scu_begin_i or reset.
- Counters are $clog2(ROW_NUM+1) bits wide. FIFO pointers are $clog2(TRACK_DEPTH)+1 bits wide and wrap naturally.
- Reset asserted mid-period returns all state and outputs to their reset values immediately, with no write issued.

## Timing
- Push in cycle t is poppable from cycle t+1.
- wb_vld_i in cycle t gives wr_en_o and wr_addr_o in cycle t+1. Both are registered, so latency is 1.
- wr_en_o is a one-cycle pulse per pop. When wr_en_o = 0, wr_addr_o holds its last value.
- track_full_o, track_empty_o and busy_o are registered and reflect state after the current edge.
- done_o is asserted in the cycle after the final pop's edge, concurrent with the last wr_en_o, and returns to 0 the next cycle.
- Back-to-back periods: scu_begin_i is honoured in the first cycle busy_o = 0.

## Structure
- memShare_config_pkg gains:
  - the FSM state enum memShare_wb_state_e;
  - localparam MEMSHARE_WB_TRACK_DEPTH = 8.
- MEMSHARE_DRC1 and MEMSHARE_DRC_NUM are reused from the package.
- One sub-module: memShare_addr_fifo, a synchronous FIFO with async active-low reset, registered read data, and full/empty outputs.
- The FSM, rebasing adder, counters and error flags live in the top module.

## Test plan
- Plain period: ROW_NUM=4, DRC off, push 0x10–0x13, then wb_vld_i for 4 cycles.
  - wr_en_o pulses with wr_addr_o = 0x10, 0x11, 0x12, 0x13.
  - done_o pulses with the 4th write; busy_o falls.
- Rebasing: drc_base_addr_i=0xF0, push 0x20 with DRC1=1.
  - Written address is 0x10 (wrap mod 256).
  - A following push of 0x21 with DRC1=0 writes 0x21.
- Overflow: TRACK_DEPTH=8, 9 pushes with no pop.
  - track_full_o=1 after 8 pushes; 9th push dropped; ovf_err_o=1.
  - Pops return the first 8 addresses only.
- Underflow plus full-with-pop:
  - wb_vld_i with the FIFO empty → wr_en_o=0, unf_err_o=1.
  - Push and pop together while full → count stays 8 and order is preserved.
- Reset mid-period: assert rstn=0 asynchronously with 3 entries queued.
  - All outputs return to reset values at once and the FSM is IDLE.
  - After release, a new scu_begin_i runs a clean period.
- Ignored inputs:
  - scu_begin_i while ACTIVE does not clear counters.
  - rd_vld_i in IDLE leaves track_empty_o=1.
